// File: rtl/mac_result_drain_if.sv
// Snapshot/drain handshake bundle for mac_result_drain.
// slave = drain block, master = snapshot source plus result consumer.
interface mac_result_drain_if #(
  parameter int NUM_MACS = 4,
  parameter int ACC_W    = 26,
  parameter int OUT_W    = 8,
  parameter int SHIFT_W  = 5
);
  localparam int IDX_W = $clog2(NUM_MACS);

  logic                      cap_valid;
  logic                      cap_ready;
  logic [NUM_MACS*ACC_W-1:0] acc_in;
  logic [SHIFT_W-1:0]        shift;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic [IDX_W-1:0]          out_index;
  logic                      out_sat;
  logic                      out_last;

  modport slave (
    input  cap_valid, acc_in, shift, out_ready,
    output cap_ready, out_valid, out_data,
    output out_index, out_sat, out_last
  );

  modport master (
    output cap_valid, acc_in, shift, out_ready,
    input  cap_ready, out_valid, out_data,
    input  out_index, out_sat, out_last
  );
endinterface

// File: rtl/mac_result_drain.sv
// Snapshots MAC accumulators, requantizes to int8 with
// round-half-up shift and saturation, streams them out.
module mac_result_drain #(
  parameter int NUM_MACS = 4,
  parameter int ACC_W    = 26,
  parameter int OUT_W    = 8,
  parameter int SHIFT_W  = 5
) (
  input logic              clk,
  input logic              reset,
  mac_result_drain_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_MACS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MACS - 1);

  localparam logic signed [ACC_W:0] RMAX =
    {{(ACC_W+1-OUT_W){1'b0}}, 1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] RMIN =
    {{(ACC_W+1-OUT_W){1'b1}}, 1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   buf_q [NUM_MACS];
  logic [SHIFT_W-1:0] shift_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               load;
  logic               cap_ready;
  logic               out_valid;
  logic               last;

  assign last = (idx_q == LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load      = 1'b0;
    cap_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        cap_ready = 1'b1;
        if (bus.cap_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        cap_ready = last && bus.out_ready;
        if (bus.out_ready) begin
          if (!last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
            if (bus.cap_valid) load = 1'b1;
            else state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      for (int i = 0; i < NUM_MACS; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        shift_q <= bus.shift;
        for (int i = 0; i < NUM_MACS; i++)
          buf_q[i] <= bus.acc_in[i*ACC_W +: ACC_W];
      end
    end
  end

  // Rounding add is one bit wider than the accumulator so it cannot wrap.
  logic signed [ACC_W:0]   ax, rnd, r;
  logic signed [OUT_W-1:0] data;
  logic                    sat;
  int                      s;

  always_comb begin
    s   = (int'(shift_q) > ACC_W - 1) ? ACC_W - 1 : int'(shift_q);
    ax  = {buf_q[idx_q][ACC_W-1], buf_q[idx_q]};
    rnd = (s == 0) ? '0 : (ACC_W+1)'(1) << (s - 1);
    r   = (ax + rnd) >>> s;
    sat = 1'b0;
    data = r[OUT_W-1:0];
    if (r > RMAX) begin
      sat  = 1'b1;
      data = RMAX[OUT_W-1:0];
    end else if (r < RMIN) begin
      sat  = 1'b1;
      data = RMIN[OUT_W-1:0];
    end
  end

  assign bus.cap_ready = cap_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data;
  assign bus.out_index = idx_q;
  assign bus.out_sat   = sat;
  assign bus.out_last  = last;
endmodule
